// File: rtl/aes_dec_if.sv
// Request/response and key-repository signals of the iterative AES inverse cipher.
// The master side is the client and key store; the slave side is aes_dec.
interface aes_dec_if;
  logic         keylength128;
  logic         keylength192;
  logic         keylength256;
  logic [0:127] ciphertext;
  logic         ciphertext_dv;
  logic         busy_exp;
  logic [3:0]   rk_sel;
  logic [0:127] rk_data;
  logic [0:127] plaintext;
  logic         plaintext_dv;
  logic         busy_dec;

  modport master (
    output keylength128, keylength192, keylength256,
    output ciphertext, ciphertext_dv, busy_exp, rk_data,
    input  rk_sel, plaintext, plaintext_dv, busy_dec
  );

  modport slave (
    input  keylength128, keylength192, keylength256,
    input  ciphertext, ciphertext_dv, busy_exp, rk_data,
    output rk_sel, plaintext, plaintext_dv, busy_dec
  );
endinterface

// File: rtl/aes_dec.sv
// Iterative AES inverse cipher (FIPS-197 InvCipher), one round per clock, 128/192/256-bit keys.
// Round keys are read by index from an external repository with a same-cycle combinational read.
module aes_inv_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  logic [7:0] pre;
  logic [7:0] sq;
  logic [7:0] acc;

  // Inverse affine transform, then multiplicative inverse as x^254 (0 maps to 0).
  always_comb begin
    pre = {din[6:0], din[7]} ^ {din[4:0], din[7:5]} ^ {din[1:0], din[7:2]} ^ 8'h05;
    sq  = pre;
    acc = 8'h01;
    for (int unsigned i = 0; i < 7; i++) begin
      sq  = gmul(sq, sq);
      acc = gmul(acc, sq);
    end
    dout = acc;
  end
endmodule

module aes_dec #(
  parameter logic BLOCK_ON_EXP = 1'b1,
  parameter logic DV_PULSE     = 1'b1
) (
  input logic       mclk,
  input logic       arst,
  aes_dec_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

  state_t       fsm;
  state_t       fsm_nxt;
  logic [3:0]   round_ctr;
  logic [3:0]   nr_in;
  logic         accept;
  logic [0:127] state_reg;
  logic [0:127] shifted;
  logic [0:127] subbed;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mulc(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    return (k[0] ? a : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
  endfunction

  function automatic logic [0:127] inv_mix(input logic [0:127] s);
    logic [0:127] o;
    logic [7:0]   a0;
    logic [7:0]   a1;
    logic [7:0]   a2;
    logic [7:0]   a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8];
      a1 = s[32*c+8 +: 8];
      a2 = s[32*c+16 +: 8];
      a3 = s[32*c+24 +: 8];
      o[32*c +: 8]    = mulc(a0, 4'he) ^ mulc(a1, 4'hb) ^ mulc(a2, 4'hd) ^ mulc(a3, 4'h9);
      o[32*c+8 +: 8]  = mulc(a0, 4'h9) ^ mulc(a1, 4'he) ^ mulc(a2, 4'hb) ^ mulc(a3, 4'hd);
      o[32*c+16 +: 8] = mulc(a0, 4'hd) ^ mulc(a1, 4'h9) ^ mulc(a2, 4'he) ^ mulc(a3, 4'hb);
      o[32*c+24 +: 8] = mulc(a0, 4'hb) ^ mulc(a1, 4'hd) ^ mulc(a2, 4'h9) ^ mulc(a3, 4'he);
    end
    return o;
  endfunction

  // Nr of the live keylength inputs; zero when the select is not one-hot.
  always_comb begin
    nr_in = '0;
    case ({bus.keylength128, bus.keylength192, bus.keylength256})
      3'b100:  nr_in = 4'd10;
      3'b010:  nr_in = 4'd12;
      3'b001:  nr_in = 4'd14;
      default: nr_in = '0;
    endcase
  end

  // Byte i is row i%4, column i/4; row r rotates right by r columns.
  always_comb begin
    shifted = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        shifted[8*(r+4*c) +: 8] = state_reg[8*(r+4*((c+4-r)%4)) +: 8];
      end
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_inv_sbox u_sbox (
      .din  (shifted[8*i +: 8]),
      .dout (subbed[8*i +: 8])
    );
  end

  always_ff @(posedge mclk or posedge arst) begin
    if (arst) fsm <= IDLE;
    else      fsm <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt    = fsm;
    bus.rk_sel = '0;
    accept     = 1'b0;
    unique case (fsm)
      IDLE: begin
        bus.rk_sel = nr_in;
        accept     = bus.ciphertext_dv && (nr_in != '0) && !(BLOCK_ON_EXP && bus.busy_exp);
        if (accept) fsm_nxt = ROUND;
      end
      ROUND: begin
        bus.rk_sel = round_ctr;
        if (round_ctr == 4'd1) fsm_nxt = FINAL;
      end
      FINAL: begin
        bus.rk_sel = '0;
        fsm_nxt    = IDLE;
      end
      default: fsm_nxt = IDLE;
    endcase
    if (arst) bus.rk_sel = '0;
  end

  always_ff @(posedge mclk or posedge arst) begin
    if (arst) begin
      state_reg        <= '0;
      round_ctr        <= '0;
      bus.plaintext    <= '0;
      bus.plaintext_dv <= 1'b0;
      bus.busy_dec     <= 1'b0;
    end else begin
      if (DV_PULSE) bus.plaintext_dv <= 1'b0;
      unique case (fsm)
        IDLE: begin
          if (accept) begin
            state_reg    <= bus.ciphertext ^ bus.rk_data;
            round_ctr    <= nr_in - 4'd1;
            bus.busy_dec <= 1'b1;
            if (!DV_PULSE) bus.plaintext_dv <= 1'b0;
          end
        end
        ROUND: begin
          state_reg <= inv_mix(subbed ^ bus.rk_data);
          round_ctr <= round_ctr - 4'd1;
        end
        FINAL: begin
          bus.plaintext    <= subbed ^ bus.rk_data;
          bus.plaintext_dv <= 1'b1;
          bus.busy_dec     <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
